// File: rtl/spi_flash_pkg.sv
// ---------------------------------------------------------------------------
// spi_flash_pkg
//   Constants and types shared by the SPI flash Read-ID controller.
//   - RDID_CMD       : JEDEC Read-ID opcode
//   - JEDEC_ID_BYTES : number of ID bytes returned after the opcode
//   - rdid_state_t   : controller FSM states
//   - cmd_bit()      : bit of an opcode for a given MSB-first bit index
// ---------------------------------------------------------------------------
package spi_flash_pkg;

   localparam logic [7:0] RDID_CMD       = 8'h9F;
   localparam int         JEDEC_ID_BYTES = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_CS_HOLD  = 3'd3,
      ST_DONE     = 3'd4
   } rdid_state_t;

   // Opcodes go out MSB first, so bit index 0 is cmd[7].
   function automatic logic cmd_bit(input logic [7:0] cmd, input logic [2:0] idx);
      return cmd[3'd7 - idx];
   endfunction

endpackage

// File: rtl/sck_tick_gen.sv
// ---------------------------------------------------------------------------
// sck_tick_gen
//   Divider that emits a one-cycle tick every CLK_DIV clk cycles. Each tick
//   marks the end of one SCK half-period (or one CS setup/hold interval).
//   The counter is held at zero while `clear` is high, so the first tick
//   after `clear` drops arrives exactly CLK_DIV cycles later.
//
// Ports
//   clk   in  system clock
//   reset in  synchronous, active-high
//   clear in  hold divider at zero (controller idle)
//   tick  out one-cycle pulse at the end of each CLK_DIV-cycle interval
// ---------------------------------------------------------------------------
module sck_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int                 CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // With CLK_DIV = 1 the counter sits at 0 and this fires every cycle.
   assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/spi_rdid_ctrl.sv
// ---------------------------------------------------------------------------
// spi_rdid_ctrl
//   Runs one JEDEC Read-ID transaction on the SPI flash (mode 0, MSB first)
//   per accepted `start` pulse and presents the captured ID with a `done`
//   pulse.
//
//   Handshake: `start` is a one-cycle request. It is accepted only on an
//   edge where the controller is idle (`busy` low); any pulse while `busy`
//   is high, including the `done` cycle, is dropped and never queued.
//   `busy` rises on the accepting edge and falls on the edge after the
//   `done` cycle. `done` is high for exactly one cycle, the same cycle in
//   which `id_data` first shows the new ID; `id_data` is otherwise stable.
//
//   Transaction shape (D = CLK_DIV):
//     CS low, D cycles setup with SCK low,
//     (8 + 8*NUM_BYTES) bit periods of D cycles low + D cycles high,
//     D cycles hold with SCK low, CS high together with `done`.
//
// Ports
//   clk      in  system clock
//   reset    in  synchronous, active-high
//   start    in  one-cycle request pulse
//   busy     out transaction in progress
//   done     out one-cycle pulse when id_data is updated
//   id_data  out captured ID, first received byte in MSBs
//   spi_cs_n out flash chip select, active low
//   spi_sck  out SPI clock, idles low
//   spi_mosi out master data out
//   spi_miso in  flash data in
// ---------------------------------------------------------------------------
module spi_rdid_ctrl
   import spi_flash_pkg::*;
#(
   parameter int         CLK_DIV   = 4,
   parameter logic [7:0] CMD       = RDID_CMD,
   parameter int         NUM_BYTES = JEDEC_ID_BYTES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [8*NUM_BYTES-1:0] id_data,
   output logic                   spi_cs_n,
   output logic                   spi_sck,
   output logic                   spi_mosi,
   input  logic                   spi_miso
);

   localparam int               ID_W       = 8 * NUM_BYTES;
   localparam int               TOTAL_BITS = 8 + ID_W;
   // One extra bit of headroom so "index + 1" never overflows.
   localparam int               BIT_W      = $clog2(TOTAL_BITS + 1);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(TOTAL_BITS - 1);
   localparam logic [BIT_W-1:0] CMD_BITS   = BIT_W'(8);

   rdid_state_t      state_q, state_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [ID_W-1:0]  shift_q, shift_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic             cs_n_q, cs_n_d;
   logic             sck_q, sck_d;
   logic             mosi_q, mosi_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             tick;
   logic [BIT_W-1:0] next_bit;

   sck_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (state_q == ST_IDLE),
      .tick  (tick)
   );

   assign next_bit = bit_cnt_q + 1'b1;

   // -------------------------------------------------------------------------
   // Next-state and next-output logic. Every output is a register, so this
   // block computes the value each register takes on the coming edge.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      id_d      = id_q;
      cs_n_d    = cs_n_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_CS_SETUP;
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
               bit_cnt_d = '0;
               shift_d   = '0;
               // Bit 0 is presented a full setup interval before the
               // first rising SCK edge.
               mosi_d    = CMD[7];
            end
         end

         ST_CS_SETUP: begin
            if (tick) begin
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (tick) begin
               if (!sck_q) begin
                  // Rising SCK: sample MISO. Samples during the opcode
                  // bits are meaningless and are not kept.
                  sck_d = 1'b1;
                  if (bit_cnt_q >= CMD_BITS) begin
                     shift_d = {shift_q[ID_W-2:0], spi_miso};
                  end
               end else begin
                  // Falling SCK: either finish or advance MOSI to the
                  // next bit (opcode bits, then zeros).
                  sck_d = 1'b0;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = ST_CS_HOLD;
                  end else begin
                     bit_cnt_d = next_bit;
                     mosi_d    = (next_bit < CMD_BITS) ?
                                 cmd_bit(CMD, next_bit[2:0]) : 1'b0;
                  end
               end
            end
         end

         ST_CS_HOLD: begin
            if (tick) begin
               state_d = ST_DONE;
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               id_d    = shift_q;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State and output registers. Reset releases CS at once, which aborts any
   // command the flash is in the middle of.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         id_q      <= '0;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         id_q      <= id_d;
         cs_n_q    <= cs_n_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign id_data  = id_q;
   assign spi_cs_n = cs_n_q;
   assign spi_sck  = sck_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_rdid_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_rdid_ctrl
//   Two controllers side by side (CLK_DIV = 4 and CLK_DIV = 1) share clk,
//   reset and start. Each talks to its own behavioural flash that returns a
//   3-byte ID chosen by the bench. A cycle-level reference model tracks,
//   for each controller, how many cycles have elapsed since its transaction
//   was accepted, and derives every expected output from that count with
//   plain arithmetic on the transaction timeline.
// ---------------------------------------------------------------------------
module tb_spi_rdid_ctrl;

   localparam int         D0  = 4;
   localparam int         D1  = 1;
   localparam logic [7:0] OPC = 8'h9F;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  busy, done, cs_n, sck, mosi, miso;
   logic [23:0] id0, id1;

   always #5 clk = ~clk;

   spi_rdid_ctrl #(.CLK_DIV(D0)) dut0 (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy[0]),
      .done     (done[0]),
      .id_data  (id0),
      .spi_cs_n (cs_n[0]),
      .spi_sck  (sck[0]),
      .spi_mosi (mosi[0]),
      .spi_miso (miso[0])
   );

   spi_rdid_ctrl #(.CLK_DIV(D1)) dut1 (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy[1]),
      .done     (done[1]),
      .id_data  (id1),
      .spi_cs_n (cs_n[1]),
      .spi_sck  (sck[1]),
      .spi_mosi (mosi[1]),
      .spi_miso (miso[1])
   );

   // ------------------------------------------------------------ checking
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------ flash model
   // The flash shifts its ID out on falling SCK edges once the 8 opcode bits
   // are in; `falls` counts completed bit periods since CS went low.
   logic [23:0] cur_id [2];
   int          falls0 = 0;
   int          falls1 = 0;

   always @(negedge sck[0] or posedge cs_n[0]) begin
      if (cs_n[0] === 1'b1) falls0 = 0;
      else                  falls0 = falls0 + 1;
   end

   always @(negedge sck[1] or posedge cs_n[1]) begin
      if (cs_n[1] === 1'b1) falls1 = 0;
      else                  falls1 = falls1 + 1;
   end

   // Opcode-phase MISO is driven high so a controller that kept those bits
   // would be caught.
   always_comb begin
      miso[0] = (falls0 >= 8 && falls0 < 32) ? cur_id[0][31 - falls0] : 1'b1;
      miso[1] = (falls1 >= 8 && falls1 < 32) ? cur_id[1][31 - falls1] : 1'b1;
   end

   // ------------------------------------------------------------ reference
   // cnt == 0: idle; cnt == k: k-th cycle after the accepting edge.
   // Cycles 1..66D have CS low, cycle 66D+1 is the done cycle.
   int unsigned cnt    [2];
   logic [23:0] exp_id [2];
   logic [23:0] id_q0 [$];

   function automatic int div_of(input int i);
      return (i == 0) ? D0 : D1;
   endfunction

   initial begin
      cnt[0] = 0; cnt[1] = 0;
      exp_id[0] = '0; exp_id[1] = '0;
      cur_id[0] = '0; cur_id[1] = '0;
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int unsigned len;
         len = 66 * div_of(i);
         if (reset) begin
            cnt[i]    = 0;
            exp_id[i] = '0;
         end else if (cnt[i] == 0) begin
            if (start) begin
               cnt[i] = 1;
               if (i == 0 && id_q0.size() > 0) cur_id[i] = id_q0.pop_front();
               else if (i == 1 && cnt[0] == 1 && id_q0.size() == 4)
                  cur_id[i] = 24'hEF4018;
               else cur_id[i] = 24'($urandom);
            end
         end else if (cnt[i] == len + 1) begin
            cnt[i] = 0;
         end else begin
            cnt[i] = cnt[i] + 1;
            if (cnt[i] == len + 1) exp_id[i] = cur_id[i];
         end
      end
   end

   // Every cycle, compare all outputs against the timeline.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int unsigned c, d, len, b;
         logic e_busy, e_done, e_cs, e_sck, e_mosi;
         logic [23:0] got_id;
         c      = cnt[i];
         d      = div_of(i);
         len    = 66 * d;
         e_busy = (c != 0);
         e_done = (c == len + 1);
         e_cs   = !(c >= 1 && c <= len);
         e_sck  = (c > d && c <= 65 * d) ? logic'(((c - 1 - d) / d) % 2) : 1'b0;
         b      = (c <= d) ? 0 : (c - 1 - d) / (2 * d);
         e_mosi = (c >= 1 && c <= len && b < 8) ? OPC[7 - b] : 1'b0;
         got_id = (i == 0) ? id0 : id1;
         check($sformatf("busy%0d c=%0d", i, c), 32'(busy[i]), 32'(e_busy));
         check($sformatf("done%0d c=%0d", i, c), 32'(done[i]), 32'(e_done));
         check($sformatf("cs_n%0d c=%0d", i, c), 32'(cs_n[i]), 32'(e_cs));
         check($sformatf("sck%0d c=%0d", i, c), 32'(sck[i]), 32'(e_sck));
         check($sformatf("mosi%0d c=%0d", i, c), 32'(mosi[i]), 32'(e_mosi));
         check($sformatf("id%0d c=%0d", i, c), 32'(got_id), 32'(exp_id[i]));
      end
   end

   // ------------------------------------------------------------ drivers
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_cnt0(input int unsigned target, input int budget);
      int n = 0;
      while (cnt[0] != target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("wait_cnt0 %0d", target), cnt[0], target);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      reset = 1'b1;
      start = 1'b0;
      id_q0.push_back(24'hEF4018);
      id_q0.push_back(24'($urandom));
      id_q0.push_back(24'($urandom));
      id_q0.push_back(24'hC22016);
      id_q0.push_back(24'h20BA19);
      repeat (3) @(negedge clk);
      check("reset_cs_n0", 32'(cs_n[0]), 32'd1);
      check("reset_id0", 32'(id0), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // First transaction on both controllers: ID EF 40 18.
      pulse_start();
      wait_cnt0(66 * D0 + 1, 400);
      check("id_ef_div4", 32'(id0), 32'hEF4018);
      check("id_ef_div1", 32'(id1), 32'hEF4018);
      @(negedge clk);

      // Starts at cycles 10 and 50 and in the done cycle are all dropped.
      pulse_start();
      wait_cnt0(10, 50);
      pulse_start();
      wait_cnt0(50, 100);
      pulse_start();
      wait_cnt0(66 * D0 + 1, 400);
      pulse_start();
      repeat (5) @(negedge clk);

      // Abort in the data phase at bit 15.
      pulse_start();
      wait_cnt0(1 + D0 + 2 * D0 * 15, 400);
      pulse_reset();
      check("abort_cs_n", 32'(cs_n[0]), 32'd1);
      check("abort_id", 32'(id0), 32'd0);
      repeat (3) @(negedge clk);

      // Normal completion, then a start in the first idle cycle.
      pulse_start();
      wait_cnt0(66 * D0 + 1, 400);
      check("id_c2", 32'(id0), 32'hC22016);
      @(negedge clk);
      pulse_start();
      wait_cnt0(66 * D0 + 1, 400);
      check("id_20ba", 32'(id0), 32'h20BA19);

      // Random starts and resets with random IDs.
      repeat (12) begin
         repeat ($urandom_range(1, 300)) @(negedge clk);
         if ($urandom_range(0, 7) == 0) pulse_reset();
         else                           pulse_start();
      end
      repeat (300) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
